// File: rtl/matrix_scan_controller.sv
// Column-multiplexed scan controller for the 5x7 LED matrix.
// Swaps in new levels only at frame boundaries and blinks the display while the level is critical.
module matrix_scan_controller #(
    parameter int CLK_DIV      = 1000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] level,
    input  logic       level_valid,
    input  logic [6:0] dec_col_1,
    input  logic [6:0] dec_col_0,
    output logic [1:0] dec_data,
    output logic [4:0] col_n,
    output logic [6:0] row_n,
    output logic       frame_start
);
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    col_idx_q, col_idx_d;
    logic [1:0]    pending_q, pending_d;
    logic [1:0]    active_q, active_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [4:0]    col_n_q, col_n_d;
    logic [6:0]    row_n_q, row_n_d;
    logic          frame_start_q, frame_start_d;
    logic          tick, frame_end;

    always_comb begin
        presc_d       = presc_q;
        col_idx_d     = col_idx_q;
        pending_d     = pending_q;
        active_d      = active_q;
        blink_cnt_d   = blink_cnt_q;
        blink_on_d    = blink_on_q;
        col_n_d       = 5'b11111;
        row_n_d       = 7'h7F;
        frame_start_d = 1'b0;
        tick          = (presc_q == PRESC_MAX);
        frame_end     = tick && (col_idx_q == 3'd4);

        // Pending keeps accepting levels even while blanked; active reads the old pending on a coinciding strobe.
        if (level_valid) begin
            pending_d = level;
        end

        if (!enable) begin
            presc_d   = '0;
            col_idx_d = 3'd0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                col_idx_d = (col_idx_q == 3'd4) ? 3'd0 : col_idx_q + 3'd1;
            end
            if (frame_end) begin
                active_d = pending_q;
            end

            if (active_q != 2'b00) begin
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end else if (frame_end) begin
                if (blink_cnt_q == BLINK_MAX) begin
                    blink_cnt_d = '0;
                    blink_on_d  = ~blink_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end

            frame_start_d = (presc_q == '0) && (col_idx_q == 3'd0);

            // First cycle of each slot stays dark so the previous column does not ghost.
            if ((presc_q != '0) && blink_on_q) begin
                col_n_d = ~(5'b00001 << col_idx_q);
                row_n_d = ((col_idx_q == 3'd0) || (col_idx_q == 3'd4)) ? ~dec_col_1 : ~dec_col_0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            col_idx_q     <= 3'd0;
            pending_q     <= 2'b00;
            active_q      <= 2'b00;
            blink_cnt_q   <= '0;
            blink_on_q    <= 1'b1;
            col_n_q       <= 5'b11111;
            row_n_q       <= 7'h7F;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            col_idx_q     <= col_idx_d;
            pending_q     <= pending_d;
            active_q      <= active_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_on_q    <= blink_on_d;
            col_n_q       <= col_n_d;
            row_n_q       <= row_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dec_data    = active_q;
    assign col_n       = col_n_q;
    assign row_n       = row_n_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller with CLK_DIV=4, BLINK_FRAMES=2 (20-cycle frames).
module tb_matrix_scan_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] level;
    logic       level_valid;
    logic [6:0] dec_col_1;
    logic [6:0] dec_col_0;
    logic [1:0] dec_data;
    logic [4:0] col_n;
    logic [6:0] row_n;
    logic       frame_start;

    int checks = 0;
    int errors = 0;

    matrix_scan_controller #(.CLK_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .level(level),
        .level_valid(level_valid), .dec_col_1(dec_col_1), .dec_col_0(dec_col_0),
        .dec_data(dec_data), .col_n(col_n), .row_n(row_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Stand-in decoder: row_n expectations below are the inverses of these patterns.
    always_comb begin
        case (dec_data)
            2'b00:   begin dec_col_1 = 7'b0000001; dec_col_0 = 7'b0000001; end
            2'b01:   begin dec_col_1 = 7'b0000111; dec_col_0 = 7'b0000011; end
            2'b10:   begin dec_col_1 = 7'b1111111; dec_col_0 = 7'b0011111; end
            default: begin dec_col_1 = 7'b1111111; dec_col_0 = 7'b1111111; end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_blank(input string tag, input logic [1:0] dd);
        check_val({tag, ".col_n"}, 32'(col_n), 32'h1F);
        check_val({tag, ".row_n"}, 32'(row_n), 32'h7F);
        check_val({tag, ".fs"}, 32'(frame_start), 32'h0);
        check_val({tag, ".dd"}, 32'(dec_data), 32'(dd));
    endtask

    // One full 20-cycle frame, starting with the scan at column 0 / prescaler 0.
    task automatic run_frame(input string name, input bit lit, input logic [6:0] r04,
                             input logic [6:0] r13, input int strobe_at, input logic [1:0] slvl,
                             input logic [1:0] dd_mid, input logic [1:0] dd_end);
        logic [4:0] onehot;
        logic [4:0] ecol;
        logic [6:0] erow;
        int pos, s;
        for (int k = 0; k < 20; k++) begin
            if (k == strobe_at) begin
                level       = slvl;
                level_valid = 1'b1;
            end
            step();
            level_valid = 1'b0;
            pos = k % 4;
            s   = k / 4;
            if (!lit || pos == 0) begin
                ecol = 5'h1F;
                erow = 7'h7F;
            end else begin
                onehot = 5'b00001 << s;
                ecol   = ~onehot;
                erow   = (s == 0 || s == 4) ? r04 : r13;
            end
            check_val($sformatf("%s.col_n[%0d]", name, k), 32'(col_n), 32'(ecol));
            check_val($sformatf("%s.row_n[%0d]", name, k), 32'(row_n), 32'(erow));
            check_val($sformatf("%s.fs[%0d]", name, k), 32'(frame_start), (k == 0) ? 32'h1 : 32'h0);
            if (k == 18) check_val($sformatf("%s.dd_mid", name), 32'(dec_data), 32'(dd_mid));
            if (k == 19) check_val($sformatf("%s.dd_end", name), 32'(dec_data), 32'(dd_end));
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        level       = 2'b00;
        level_valid = 1'b0;
        repeat (3) step();
        check_blank("reset", 2'b00);
        reset = 1'b0;
        step();
        check_blank("idle", 2'b00);

        // Scan walk; level 11 strobed on the first enabled cycle reaches active at frame end.
        enable = 1'b1;
        run_frame("f1", 1'b1, 7'h7E, 7'h7E, 0, 2'b11, 2'b00, 2'b11);
        run_frame("f2", 1'b1, 7'h00, 7'h00, -1, 2'b00, 2'b11, 2'b11);

        // Level 10 strobed mid-frame, then displayed the following frame.
        run_frame("f3", 1'b1, 7'h00, 7'h00, 4, 2'b10, 2'b11, 2'b10);
        run_frame("f4", 1'b1, 7'h00, 7'h60, -1, 2'b00, 2'b10, 2'b10);

        // Strobe on the frame_end cycle is deferred by one frame.
        run_frame("f5", 1'b1, 7'h00, 7'h60, 19, 2'b01, 2'b10, 2'b10);
        run_frame("f6", 1'b1, 7'h00, 7'h60, -1, 2'b00, 2'b10, 2'b01);

        // Critical level: lit 2 frames, dark 2, lit 2, dark; level 01 while dark stops blinking.
        run_frame("f7", 1'b1, 7'h78, 7'h7C, 5, 2'b00, 2'b01, 2'b00);
        run_frame("b1", 1'b1, 7'h7E, 7'h7E, -1, 2'b00, 2'b00, 2'b00);
        run_frame("b2", 1'b1, 7'h7E, 7'h7E, -1, 2'b00, 2'b00, 2'b00);
        run_frame("b3", 1'b0, 7'h7E, 7'h7E, -1, 2'b00, 2'b00, 2'b00);
        run_frame("b4", 1'b0, 7'h7E, 7'h7E, -1, 2'b00, 2'b00, 2'b00);
        run_frame("b5", 1'b1, 7'h7E, 7'h7E, -1, 2'b00, 2'b00, 2'b00);
        run_frame("b6", 1'b1, 7'h7E, 7'h7E, -1, 2'b00, 2'b00, 2'b00);
        run_frame("b7", 1'b0, 7'h7E, 7'h7E, 3, 2'b01, 2'b00, 2'b01);
        run_frame("b8", 1'b1, 7'h78, 7'h7C, -1, 2'b00, 2'b01, 2'b01);

        // Enable dropped in the column 2 slot for 7 cycles; pending still loads meanwhile.
        repeat (9) step();
        enable      = 1'b0;
        level       = 2'b11;
        level_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            level_valid = 1'b0;
            check_blank($sformatf("dis[%0d]", i), 2'b01);
        end
        enable = 1'b1;
        run_frame("reen", 1'b1, 7'h78, 7'h7C, -1, 2'b00, 2'b01, 2'b11);
        run_frame("f11", 1'b1, 7'h00, 7'h00, -1, 2'b00, 2'b11, 2'b11);

        // Reset mid-frame with level 11 active.
        repeat (7) step();
        reset = 1'b1;
        step();
        check_blank("midrst", 2'b00);
        reset = 1'b0;
        run_frame("post", 1'b1, 7'h7E, 7'h7E, -1, 2'b00, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
